serial_adder4: RTL and testbench
================================

// Module: serial_adder4
// PURPOSE
//  Bit-serial adder for four operands streamed LSB-first, one bit per clock.
//  Each cycle it adds the four input bits plus an internal 2-bit carry, emits
//  one result bit and keeps the remaining carry for the next bit position.
//  Used as a compact multi-operand accumulator on serial datapaths. Word
//  framing is done externally by asserting rst between words.
// PARAMETERS
//  none; all widths are fixed by the 4-operand structure.
// PORTS
//  clk  in   1  single clock; all state updates on rising edge
//  rst  in   1  synchronous, active-high reset; clears carry and sum
//  a    in   1  operand A, current bit (LSB first)
//  b    in   1  operand B, current bit
//  c    in   1  operand C, current bit
//  d    in   1  operand D, current bit
//  sum  out  1  registered result bit, one cycle after its operand bits
// BEHAVIOUR
//  - One clock clk; reset is synchronous and active-high (rst), sampled on posedge clk only.
//  - State: carry_q[1:0], sum_q (drives sum).
//  - Every posedge with rst=0:
//    total[2:0] = a+b+c+d+carry_q (0..7);
//    sum_q <= total[0]; carry_q <= total[2:1].
//  - Width closure: max total = 4+3 = 7, so carry never exceeds 3 and
//    2 carry bits always suffice. No overflow or saturation logic.
//  - Latency: exactly 1 cycle. Operand bits sampled at edge k appear on sum
//    after edge k. Output is glitch-free and depends only on registers.
//  - Reset: posedge with rst=1 gives carry_q=0, sum=0; operands are ignored
//    that cycle. Reset mid-word aborts the word and discards the carry.
//  - No internal word length. Carry persists indefinitely. Once operands
//    go to 0, the pending carry drains out on sum over at most 2 cycles.
//  - Inputs must be stable around the rising edge. X on inputs must not
//    reach state after rst is asserted.
// TESTING
//  - Reset: rst=1 for 1 edge with any inputs -> sum=0, carry_q=0. Then hold
//    a..d=0 for 5 edges -> sum stays 0.
//  - Single operand: a=1,b=c=d=0 for 3 edges -> sum=1 each cycle, carry 0.
//  - Word add 3+1+2+0, 4 bits LSB-first: a=1,1,0,0 b=1,0,0,0 c=0,1,0,0
//    d=0 -> sum=0,1,1,0 (=6) on the following cycles.
//  - Carry saturation: a..d=1 for 4 edges -> sum=0,0,1,1, carry=2,3,3,3.
//    Then a..d=0 for 3 edges -> sum=1,1,0 (carry 3 drains).
//  - Mid-word reset: load carry=3 as above, assert rst for 1 edge, then
//    a..d=0 -> sum=0 immediately and thereafter.
//  - Random: 10+ cycles of $random bits compared against a reference model
//    total=a+b+c+d+carry; sum must match with 1-cycle lag.

Source files
------------

// File: rtl/serial_adder4.sv
// Bit-serial four-operand adder: operands arrive LSB-first, one bit per clock,
// and a 2-bit carry is held between bit positions; the result bit is registered.
module serial_adder4 (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic sum
);

    localparam int unsigned TOTAL_W = 3;
    localparam int unsigned CARRY_W = 2;

    logic [CARRY_W-1:0] carry_q;
    logic [CARRY_W-1:0] carry_d;
    logic               sum_q;
    logic               sum_d;
    logic [TOTAL_W-1:0] total;

    // Four input bits plus carry peak at 7, so three total bits and two carry bits suffice.
    always_comb begin
        total   = TOTAL_W'(a) + TOTAL_W'(b) + TOTAL_W'(c) + TOTAL_W'(d) + TOTAL_W'(carry_q);
        sum_d   = total[0];
        carry_d = total[TOTAL_W-1:1];
        if (rst) begin
            sum_d   = 1'b0;
            carry_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
    end

    assign sum = sum_q;

endmodule

// File: tb/tb_serial_adder4.sv
// Directed and random checks of serial_adder4 against hand-computed sums and a
// small carry model; sum and carry are sampled 1 ns after each rising edge.
module tb_serial_adder4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a   = 1'b0;
    logic b   = 1'b0;
    logic c   = 1'b0;
    logic d   = 1'b0;
    logic sum;

    int n_cmp  = 0;
    int n_fail = 0;

    serial_adder4 dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .sum (sum)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one bit position, then let one edge pass and settle.
    task automatic drive(input logic r, input logic ia, input logic ib,
                         input logic ic, input logic id);
        rst = r;
        a   = ia;
        b   = ib;
        c   = ic;
        d   = id;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] wa;
        logic [3:0] wb;
        logic [3:0] wc;
        logic [3:0] ws;
        logic [3:0] sat_s;
        logic [7:0] sat_c;
        logic [2:0] drain_s;
        logic [1:0] m_carry;
        logic [2:0] total;
        logic       ra;
        logic       rb;
        logic       rc;
        logic       rd;

        // Reset with all operands high must still clear state.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check_val("reset_sum", 2'(sum), 2'd0);
        check_val("reset_carry", dut.carry_q, 2'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check_val($sformatf("idle_sum[%0d]", i), 2'(sum), 2'd0);
        end

        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            check_val($sformatf("single_sum[%0d]", i), 2'(sum), 2'd1);
            check_val($sformatf("single_carry[%0d]", i), dut.carry_q, 2'd0);
        end

        // 3 + 1 + 2 + 0 = 6, LSB-first.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        wa = 4'b0011;
        wb = 4'b0001;
        wc = 4'b0010;
        ws = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, wa[i], wb[i], wc[i], 1'b0);
            check_val($sformatf("word_sum[%0d]", i), 2'(sum), 2'(ws[i]));
        end

        // All ones: sum 0,0,1,1 with carry 2,3,3,3; then carry 3 drains as 1,1,0.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sat_s   = 4'b1100;
        sat_c   = {2'd3, 2'd3, 2'd3, 2'd2};
        drain_s = 3'b011;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
            check_val($sformatf("sat_sum[%0d]", i), 2'(sum), 2'(sat_s[i]));
            check_val($sformatf("sat_carry[%0d]", i), dut.carry_q, sat_c[2*i +: 2]);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check_val($sformatf("drain_sum[%0d]", i), 2'(sum), 2'(drain_s[i]));
        end

        // Load carry 3, then a mid-word reset must discard it.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        end
        check_val("preload_carry", dut.carry_q, 2'd3);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check_val("midrst_sum", 2'(sum), 2'd0);
        check_val("midrst_carry", dut.carry_q, 2'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check_val($sformatf("post_rst_sum[%0d]", i), 2'(sum), 2'd0);
        end

        // Random operand bits against a reference carry model.
        m_carry = 2'd0;
        for (int i = 0; i < 24; i++) begin
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            total   = 3'(ra) + 3'(rb) + 3'(rc) + 3'(rd) + 3'(m_carry);
            m_carry = total[2:1];
            drive(1'b0, ra, rb, rc, rd);
            check_val($sformatf("rand_sum[%0d]", i), 2'(sum), 2'(total[0]));
            check_val($sformatf("rand_carry[%0d]", i), dut.carry_q, m_carry);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
